// File: rtl/hilo_writeback_pipe_pkg.sv
// Shared constants and types for the HI/LO writeback pipe: data width, reset level,
// slot packing width and the forward-source selector.
package hilo_writeback_pipe_pkg;

   localparam int   REG_DATA_WIDTH = 32;
   localparam logic RST_ENABLE     = 1'b1;

   typedef enum logic [1:0] {
      FWD_ARCH = 2'd0,
      FWD_WB   = 2'd1,
      FWD_MEM  = 2'd2
   } fwd_src_e;

   // One slot packs {we_hi, we_lo, hi, lo}.
   function automatic int hilo_slot_width(input int data_width);
      return 2 * data_width + 2;
   endfunction

endpackage

// File: rtl/hilo_slot_reg.sv
// One pipeline slot (MEM or WB) holding a pending HI/LO write: two enables plus data.
// clear drops both enables and beats load; with neither asserted the slot holds.
module hilo_slot_reg
   import hilo_writeback_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clear,
   input  logic                  we_hi,
   input  logic                  we_lo,
   input  logic [DATA_WIDTH-1:0] hi,
   input  logic [DATA_WIDTH-1:0] lo,
   output logic                  q_we_hi,
   output logic                  q_we_lo,
   output logic [DATA_WIDTH-1:0] q_hi,
   output logic [DATA_WIDTH-1:0] q_lo
);

   localparam int SLOT_W = hilo_slot_width(DATA_WIDTH);

   logic [SLOT_W-1:0] slot_d;
   logic [SLOT_W-1:0] slot_q;

   always_comb begin
      // NOTE: slot_d takes a default before any branch so no path leaves it unassigned (no latch).
      slot_d = slot_q;
      if (clear) begin
         slot_d[SLOT_W-1 -: 2] = 2'b00;
      end else if (load) begin
         slot_d = {we_hi, we_lo, hi, lo};
      end
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign {q_we_hi, q_we_lo, q_hi, q_lo} = slot_q;

endmodule

// File: rtl/hilo_writeback_pipe.sv
// Carries EX-stage HI/LO writes through MEM and WB slots, commits them to HI/LO and
// drives the mfhi/mflo read values. Define HILO_BYPASS_EN to forward from MEM/WB.
module hilo_writeback_pipe
   import hilo_writeback_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  ex_we_hi,
   input  logic                  ex_we_lo,
   input  logic [DATA_WIDTH-1:0] ex_hi,
   input  logic [DATA_WIDTH-1:0] ex_lo,
   input  logic                  ex_is_overflow,
   output logic [DATA_WIDTH-1:0] hi_rd,
   output logic [DATA_WIDTH-1:0] lo_rd,
   output logic [DATA_WIDTH-1:0] hi_q,
   output logic [DATA_WIDTH-1:0] lo_q,
   output logic                  hilo_busy
);

   logic                  ex_ok_we_hi, ex_ok_we_lo;
   logic                  mem_we_hi, mem_we_lo, wb_we_hi, wb_we_lo;
   logic [DATA_WIDTH-1:0] mem_hi, mem_lo, wb_hi, wb_lo;
   logic [DATA_WIDTH-1:0] hi_d, lo_d;

   // An overflowing ALU op must not disturb HI/LO.
   assign ex_ok_we_hi = ex_we_hi & ~ex_is_overflow;
   assign ex_ok_we_lo = ex_we_lo & ~ex_is_overflow;

   hilo_slot_reg #(.DATA_WIDTH(DATA_WIDTH)) u_mem_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (~stall),
      .clear   (flush),
      .we_hi   (ex_ok_we_hi),
      .we_lo   (ex_ok_we_lo),
      .hi      (ex_hi),
      .lo      (ex_lo),
      .q_we_hi (mem_we_hi),
      .q_we_lo (mem_we_lo),
      .q_hi    (mem_hi),
      .q_lo    (mem_lo)
   );

   // A stalled MEM slot must not also advance, so WB takes a bubble instead.
   hilo_slot_reg #(.DATA_WIDTH(DATA_WIDTH)) u_wb_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (1'b1),
      .clear   (stall | flush),
      .we_hi   (mem_we_hi),
      .we_lo   (mem_we_lo),
      .hi      (mem_hi),
      .lo      (mem_lo),
      .q_we_hi (wb_we_hi),
      .q_we_lo (wb_we_lo),
      .q_hi    (wb_hi),
      .q_lo    (wb_lo)
   );

   always_comb begin
      hi_d = wb_we_hi ? wb_hi : hi_q;
      lo_d = wb_we_lo ? wb_lo : lo_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

`ifdef HILO_BYPASS_EN
   fwd_src_e hi_src, lo_src;

   // Youngest pending write wins; EX itself is never forwarded to avoid an ALU loop.
   always_comb begin
      hi_src = FWD_ARCH;
      lo_src = FWD_ARCH;
      if (mem_we_hi)     hi_src = FWD_MEM;
      else if (wb_we_hi) hi_src = FWD_WB;
      if (mem_we_lo)     lo_src = FWD_MEM;
      else if (wb_we_lo) lo_src = FWD_WB;
   end

   always_comb begin
      hi_rd = hi_q;
      lo_rd = lo_q;
      unique case (hi_src)
         FWD_MEM: hi_rd = mem_hi;
         FWD_WB:  hi_rd = wb_hi;
         default: hi_rd = hi_q;
      endcase
      unique case (lo_src)
         FWD_MEM: lo_rd = mem_lo;
         FWD_WB:  lo_rd = wb_lo;
         default: lo_rd = lo_q;
      endcase
   end

   assign hilo_busy = 1'b0;
`else
   assign hi_rd     = hi_q;
   assign lo_rd     = lo_q;
   assign hilo_busy = mem_we_hi | mem_we_lo | wb_we_hi | wb_we_lo;
`endif

endmodule

// File: tb/tb_hilo_writeback_pipe.sv
// Self-checking bench for hilo_writeback_pipe: directed scenarios then random traffic,
// compared each cycle against a queue-of-pending-writes reference model.
module tb_hilo_writeback_pipe;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         stall, flush;
   logic         ex_we_hi, ex_we_lo, ex_is_overflow;
   logic [W-1:0] ex_hi, ex_lo;
   logic [W-1:0] hi_rd, lo_rd, hi_q, lo_q;
   logic         hilo_busy;

   hilo_writeback_pipe #(.DATA_WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .ex_we_hi       (ex_we_hi),
      .ex_we_lo       (ex_we_lo),
      .ex_hi          (ex_hi),
      .ex_lo          (ex_lo),
      .ex_is_overflow (ex_is_overflow),
      .hi_rd          (hi_rd),
      .lo_rd          (lo_rd),
      .hi_q           (hi_q),
      .lo_q           (lo_q),
      .hilo_busy      (hilo_busy)
   );

   always #5 clk = ~clk;

   // Reference model: architectural values plus an age-ordered list of in-flight writes.
   typedef struct {
      bit         we_hi;
      bit         we_lo;
      logic [31:0] hi;
      logic [31:0] lo;
      int         stage;   // 1 = waiting in MEM, 2 = waiting in WB
   } wr_t;

   wr_t         inflight[$];
   logic [31:0] m_hi, m_lo;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      inflight = {};
      m_hi     = '0;
      m_lo     = '0;
   endtask

   task automatic model_edge(input bit st, input bit fl, input bit whi, input bit wlo,
                             input bit ovf, input logic [31:0] h, input logic [31:0] l);
      wr_t nq[$];
      wr_t w;
      nq = {};
      foreach (inflight[i]) begin
         w = inflight[i];
         if (w.stage == 2) begin
            if (w.we_hi) m_hi = w.hi;
            if (w.we_lo) m_lo = w.lo;
         end else if (!fl) begin
            if (!st) w.stage = 2;
            nq.push_back(w);
         end
      end
      if (!fl && !st && !ovf && (whi || wlo)) begin
         w.we_hi = whi;
         w.we_lo = wlo;
         w.hi    = h;
         w.lo    = l;
         w.stage = 1;
         nq.push_back(w);
      end
      inflight = nq;
   endtask

   function automatic logic [31:0] exp_hi_rd();
`ifdef HILO_BYPASS_EN
      for (int i = inflight.size() - 1; i >= 0; i--)
         if (inflight[i].we_hi) return inflight[i].hi;
`endif
      return m_hi;
   endfunction

   function automatic logic [31:0] exp_lo_rd();
`ifdef HILO_BYPASS_EN
      for (int i = inflight.size() - 1; i >= 0; i--)
         if (inflight[i].we_lo) return inflight[i].lo;
`endif
      return m_lo;
   endfunction

   function automatic logic [31:0] exp_busy();
`ifdef HILO_BYPASS_EN
      return 32'd0;
`else
      return (inflight.size() != 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   task automatic check_all(input string tag);
      check({tag, "/hi_rd"}, hi_rd, exp_hi_rd());
      check({tag, "/lo_rd"}, lo_rd, exp_lo_rd());
      check({tag, "/hi_q"},  hi_q,  m_hi);
      check({tag, "/lo_q"},  lo_q,  m_lo);
      check({tag, "/busy"},  {31'd0, hilo_busy}, exp_busy());
   endtask

   // Drive one cycle of inputs, take the edge, then compare 1 time unit later.
   task automatic cycle(input string tag, input bit st, input bit fl, input bit whi,
                        input bit wlo, input bit ovf, input logic [31:0] h,
                        input logic [31:0] l);
      stall          = st;
      flush          = fl;
      ex_we_hi       = whi;
      ex_we_lo       = wlo;
      ex_is_overflow = ovf;
      ex_hi          = h;
      ex_lo          = l;
      @(posedge clk);
      model_edge(st, fl, whi, wlo, ovf, h, l);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      check({tag, "/hi_q_zero"}, hi_q, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [31:0] busy_pend;
   bit          r_st, r_fl, r_whi, r_wlo, r_ovf;

   initial begin
`ifdef HILO_BYPASS_EN
      busy_pend = 32'd0;
`else
      busy_pend = 32'd1;
`endif
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      ex_we_hi = 1'b0; ex_we_lo = 1'b0; ex_is_overflow = 1'b0;
      ex_hi = '0; ex_lo = '0;
      model_reset();
      #3;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Mult result: forwarded after one edge, architectural after three.
      cycle("mult_e1", 0, 0, 1, 1, 0, 32'h0000_0001, 32'hFFFF_FFFE);
      idle("mult_e2");
      idle("mult_e3");
      check("mult_hi_q", hi_q, 32'h0000_0001);
      check("mult_lo_q", lo_q, 32'hFFFF_FFFE);

      // Back-to-back HI writes: MEM beats WB on the read path, commits in order.
      cycle("b2b_e1", 0, 0, 1, 0, 0, 32'hA, 32'h1234);
      cycle("b2b_e2", 0, 0, 1, 0, 0, 32'hB, 32'h5678);
      idle("b2b_e3");
      check("b2b_hi_q_a", hi_q, 32'hA);
      idle("b2b_e4");
      check("b2b_hi_q_b", hi_q, 32'hB);
      check("b2b_lo_q_kept", lo_q, 32'hFFFF_FFFE);

      // Overflow suppresses both halves.
      cycle("ovf_e1", 0, 0, 1, 1, 1, 32'hDEAD, 32'hDEAD);
      check("ovf_busy", {31'd0, hilo_busy}, 32'd0);
      idle("ovf_e2");
      idle("ovf_e3");
      check("ovf_hi_q", hi_q, 32'hB);

      // LO write held in MEM by a two-cycle stall; commits two edges after release.
      cycle("stl_e1", 0, 0, 0, 1, 0, 32'h0, 32'h55);
      cycle("stl_s1", 1, 0, 1, 1, 0, 32'h99, 32'h99);
      cycle("stl_s2", 1, 0, 0, 0, 0, 32'h0, 32'h0);
      idle("stl_r1");
      check("stl_lo_q_old", lo_q, 32'hFFFF_FFFE);
      idle("stl_r2");
      check("stl_lo_q_new", lo_q, 32'h55);

      // Flush arriving during a stall kills the held write.
      cycle("fl_e1", 0, 0, 0, 1, 0, 32'h0, 32'h66);
      cycle("fl_s1", 1, 0, 0, 0, 0, 32'h0, 32'h0);
      cycle("fl_sf", 1, 1, 0, 0, 0, 32'h0, 32'h0);
      cycle("fl_s2", 1, 0, 0, 0, 0, 32'h0, 32'h0);
      idle("fl_r1");
      idle("fl_r2");
      idle("fl_r3");
      check("fl_lo_q", lo_q, 32'h55);

      // Busy window for a single HI write.
      cycle("busy_e1", 0, 0, 1, 0, 0, 32'h7, 32'h0);
      check("busy_e1_flag", {31'd0, hilo_busy}, busy_pend);
      idle("busy_e2");
      check("busy_e2_flag", {31'd0, hilo_busy}, busy_pend);
      idle("busy_e3");
      check("busy_e3_flag", {31'd0, hilo_busy}, 32'd0);
      check("busy_hi_q", hi_q, 32'h7);

      // Async reset with writes in both MEM and WB; nothing may commit afterwards.
      cycle("rst_e1", 0, 0, 1, 1, 0, 32'h11, 32'h22);
      cycle("rst_e2", 0, 0, 1, 0, 0, 32'h33, 32'h0);
      async_reset("rst_mid");
      idle("rst_r1");
      idle("rst_r2");
      idle("rst_r3");
      check("rst_hi_q", hi_q, 32'h0);
      check("rst_lo_q", lo_q, 32'h0);

      // Random traffic with occasional stall, flush and overflow.
      for (int i = 0; i < 300; i++) begin
         if (i == 150) async_reset("rnd_rst");
         r_st  = ($urandom % 5) == 0;
         r_fl  = ($urandom % 7) == 0;
         r_whi = $urandom % 2;
         r_wlo = $urandom % 2;
         r_ovf = ($urandom % 6) == 0;
         cycle("rnd", r_st, r_fl, r_whi, r_wlo, r_ovf, $urandom, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
